// File: rtl/tilelink_n_to_1_arbiter.sv
// tilelink_n_to_1_arbiter: round-robin M-to-1 TileLink-UL A-channel arbiter with burst lock
// and source-indexed D-channel demultiplexing.
module tilelink_n_to_1_arbiter #(
    parameter int M     = 2,
    parameter int TL_DW = 32,
    parameter int TL_AW = 32,
    parameter int TL_RS = 4,
    parameter int TL_SZ = 4,
    localparam int MW   = $clog2(M)
) (
    input  logic                    tilelink_clock_i,
    input  logic                    tilelink_reset_i,
    input  logic [3*M-1:0]          master_a_opcode,
    input  logic [3*M-1:0]          master_a_param,
    input  logic [TL_SZ*M-1:0]      master_a_size,
    input  logic [TL_RS*M-1:0]      master_a_source,
    input  logic [TL_AW*M-1:0]      master_a_address,
    input  logic [TL_DW/8*M-1:0]    master_a_mask,
    input  logic [TL_DW*M-1:0]      master_a_data,
    input  logic [M-1:0]            master_a_corrupt,
    input  logic [M-1:0]            master_a_valid,
    output logic [M-1:0]            master_a_ready,
    output logic [3*M-1:0]          master_d_opcode,
    output logic [2*M-1:0]          master_d_param,
    output logic [TL_SZ*M-1:0]      master_d_size,
    output logic [TL_RS*M-1:0]      master_d_source,
    output logic [M-1:0]            master_d_denied,
    output logic [M-1:0]            master_d_corrupt,
    output logic [M-1:0]            master_d_valid,
    output logic [TL_DW*M-1:0]      master_d_data,
    input  logic [M-1:0]            master_d_ready,
    output logic [2:0]              slave_a_opcode,
    output logic [2:0]              slave_a_param,
    output logic [TL_SZ-1:0]        slave_a_size,
    output logic [TL_RS+MW-1:0]     slave_a_source,
    output logic [TL_AW-1:0]        slave_a_address,
    output logic [TL_DW/8-1:0]      slave_a_mask,
    output logic [TL_DW-1:0]        slave_a_data,
    output logic                    slave_a_corrupt,
    output logic                    slave_a_valid,
    input  logic                    slave_a_ready,
    input  logic [2:0]              slave_d_opcode,
    input  logic [1:0]              slave_d_param,
    input  logic [TL_SZ-1:0]        slave_d_size,
    input  logic [TL_RS+MW-1:0]     slave_d_source,
    input  logic                    slave_d_denied,
    input  logic                    slave_d_corrupt,
    input  logic                    slave_d_valid,
    input  logic [TL_DW-1:0]        slave_d_data,
    output logic                    slave_d_ready
);
    localparam int LB = $clog2(TL_DW / 8);
    localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q;
    logic [MW-1:0]       rr_q, lock_q, grant, sel, d_idx;
    logic [11:0]         cnt_q, beats_m1;
    logic                found, slot_free, accept, is_burst;
    logic [2:0]          sel_opcode;
    logic [TL_SZ-1:0]    sel_size;

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = M - 1; i >= 0; i--) begin
            if (master_a_valid[(int'(rr_q) + i) % M]) begin
                grant = MW'((int'(rr_q) + i) % M);
                found = 1'b1;
            end
        end
    end

    assign slot_free      = !slave_a_valid || slave_a_ready;
    assign sel            = (state_q == BURST) ? lock_q : grant;
    assign master_a_ready = (!tilelink_reset_i && slot_free && (state_q == BURST || found)) ? ONE << sel : '0;
    assign accept         = |(master_a_ready & master_a_valid);
    assign sel_opcode     = master_a_opcode[int'(sel)*3 +: 3];
    assign sel_size       = master_a_size[int'(sel)*TL_SZ +: TL_SZ];
    assign is_burst       = (sel_opcode == 3'd0 || sel_opcode == 3'd1) && int'(sel_size) > LB;
    assign beats_m1       = 12'((1 << (int'(sel_size) - LB)) - 1);

    always_ff @(posedge tilelink_clock_i) begin
        if (tilelink_reset_i) begin
            state_q         <= IDLE;
            rr_q            <= '0;
            lock_q          <= '0;
            cnt_q           <= '0;
            slave_a_valid   <= 1'b0;
            slave_a_opcode  <= '0;
            slave_a_param   <= '0;
            slave_a_size    <= '0;
            slave_a_source  <= '0;
            slave_a_address <= '0;
            slave_a_mask    <= '0;
            slave_a_data    <= '0;
            slave_a_corrupt <= 1'b0;
        end else begin
            if (slot_free) slave_a_valid <= accept;
            if (accept) begin
                slave_a_opcode  <= sel_opcode;
                slave_a_param   <= master_a_param[int'(sel)*3 +: 3];
                slave_a_size    <= sel_size;
                slave_a_source  <= {sel, master_a_source[int'(sel)*TL_RS +: TL_RS]};
                slave_a_address <= master_a_address[int'(sel)*TL_AW +: TL_AW];
                slave_a_mask    <= master_a_mask[int'(sel)*(TL_DW/8) +: TL_DW/8];
                slave_a_data    <= master_a_data[int'(sel)*TL_DW +: TL_DW];
                slave_a_corrupt <= master_a_corrupt[sel];
                if (state_q == IDLE) begin
                    rr_q <= MW'((int'(sel) + 1) % M);
                    if (is_burst) begin
                        state_q <= BURST;
                        lock_q  <= sel;
                        cnt_q   <= beats_m1;
                    end
                end else begin
                    cnt_q <= cnt_q - 12'd1;
                    if (cnt_q == 12'd1) state_q <= IDLE;
                end
            end
        end
    end

    assign d_idx            = slave_d_source[TL_RS+MW-1 -: MW];
    assign master_d_valid   = slave_d_valid ? ONE << d_idx : '0;
    assign slave_d_ready    = (int'(d_idx) < M) ? master_d_ready[d_idx] : 1'b1;
    assign master_d_opcode  = {M{slave_d_opcode}};
    assign master_d_param   = {M{slave_d_param}};
    assign master_d_size    = {M{slave_d_size}};
    assign master_d_source  = {M{slave_d_source[TL_RS-1:0]}};
    assign master_d_denied  = {M{slave_d_denied}};
    assign master_d_corrupt = {M{slave_d_corrupt}};
    assign master_d_data    = {M{slave_d_data}};
endmodule

// File: tb/tb_tilelink_n_to_1_arbiter.sv
// tb_tilelink_n_to_1_arbiter: directed scenario tests for the M=2 arbiter configuration.
module tb_tilelink_n_to_1_arbiter;
    localparam int M = 2, DW = 32, AW = 32, RS = 4, SZ = 4, MW = 1;

    logic                 clk = 1'b0, rst = 1'b1;
    logic [3*M-1:0]       m_a_opcode = '0, m_a_param = '0;
    logic [SZ*M-1:0]      m_a_size = '0;
    logic [RS*M-1:0]      m_a_source = '0;
    logic [AW*M-1:0]      m_a_address = '0;
    logic [DW/8*M-1:0]    m_a_mask = '0;
    logic [DW*M-1:0]      m_a_data = '0;
    logic [M-1:0]         m_a_corrupt = '0, m_a_valid = '0, m_a_ready;
    logic [3*M-1:0]       m_d_opcode;
    logic [2*M-1:0]       m_d_param;
    logic [SZ*M-1:0]      m_d_size;
    logic [RS*M-1:0]      m_d_source;
    logic [M-1:0]         m_d_denied, m_d_corrupt, m_d_valid;
    logic [DW*M-1:0]      m_d_data;
    logic [M-1:0]         m_d_ready = '1;
    logic [2:0]           s_a_opcode, s_a_param;
    logic [SZ-1:0]        s_a_size;
    logic [RS+MW-1:0]     s_a_source;
    logic [AW-1:0]        s_a_address;
    logic [DW/8-1:0]      s_a_mask;
    logic [DW-1:0]        s_a_data;
    logic                 s_a_corrupt, s_a_valid;
    logic                 s_a_ready = 1'b1;
    logic [2:0]           s_d_opcode = 3'd1;
    logic [1:0]           s_d_param = '0;
    logic [SZ-1:0]        s_d_size = 4'd2;
    logic [RS+MW-1:0]     s_d_source = '0;
    logic                 s_d_denied = 1'b0, s_d_corrupt = 1'b0, s_d_valid = 1'b0;
    logic [DW-1:0]        s_d_data = 32'hDEAD_BEEF;
    logic                 s_d_ready;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    tilelink_n_to_1_arbiter #(.M(M), .TL_DW(DW), .TL_AW(AW), .TL_RS(RS), .TL_SZ(SZ)) dut (
        .tilelink_clock_i(clk), .tilelink_reset_i(rst),
        .master_a_opcode(m_a_opcode), .master_a_param(m_a_param), .master_a_size(m_a_size),
        .master_a_source(m_a_source), .master_a_address(m_a_address), .master_a_mask(m_a_mask),
        .master_a_data(m_a_data), .master_a_corrupt(m_a_corrupt), .master_a_valid(m_a_valid),
        .master_a_ready(m_a_ready),
        .master_d_opcode(m_d_opcode), .master_d_param(m_d_param), .master_d_size(m_d_size),
        .master_d_source(m_d_source), .master_d_denied(m_d_denied), .master_d_corrupt(m_d_corrupt),
        .master_d_valid(m_d_valid), .master_d_data(m_d_data), .master_d_ready(m_d_ready),
        .slave_a_opcode(s_a_opcode), .slave_a_param(s_a_param), .slave_a_size(s_a_size),
        .slave_a_source(s_a_source), .slave_a_address(s_a_address), .slave_a_mask(s_a_mask),
        .slave_a_data(s_a_data), .slave_a_corrupt(s_a_corrupt), .slave_a_valid(s_a_valid),
        .slave_a_ready(s_a_ready),
        .slave_d_opcode(s_d_opcode), .slave_d_param(s_d_param), .slave_d_size(s_d_size),
        .slave_d_source(s_d_source), .slave_d_denied(s_d_denied), .slave_d_corrupt(s_d_corrupt),
        .slave_d_valid(s_d_valid), .slave_d_data(s_d_data), .slave_d_ready(s_d_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int m, input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src,
                         input logic [31:0] addr, input logic [31:0] dat);
        m_a_opcode[m*3 +: 3]   = op;
        m_a_size[m*SZ +: SZ]   = sz;
        m_a_source[m*RS +: RS] = src;
        m_a_address[m*AW +: AW] = addr;
        m_a_data[m*DW +: DW]   = dat;
        m_a_mask[m*4 +: 4]     = 4'hF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_a_valid = 2'b11;
        set_a(0, 3'd4, 4'd2, 4'd1, 32'h0, 32'h0);
        set_a(1, 3'd4, 4'd2, 4'd2, 32'h4, 32'h0);
        tick();
        tick();
        checks++; if (s_a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", s_a_valid); end
        checks++; if (s_a_source !== 5'h00) begin errors++; $display("FAIL reset_source got %h exp 00", s_a_source); end
        checks++; if (m_a_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", m_a_ready); end
        m_a_valid = 2'b00;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_get();
        s_a_ready = 1'b1;
        set_a(1, 3'd4, 4'd2, 4'd3, 32'h100, 32'h0);
        m_a_valid = 2'b10;
        #1;
        checks++; if (m_a_ready !== 2'b10) begin errors++; $display("FAIL get_ready got %b exp 10", m_a_ready); end
        tick();
        m_a_valid = 2'b00;
        checks++; if (s_a_valid !== 1'b1) begin errors++; $display("FAIL get_valid got %b exp 1", s_a_valid); end
        checks++; if (s_a_source !== 5'h13) begin errors++; $display("FAIL get_source got %h exp 13", s_a_source); end
        checks++; if (s_a_address !== 32'h100) begin errors++; $display("FAIL get_addr got %h exp 100", s_a_address); end
        checks++; if (s_a_opcode !== 3'd4) begin errors++; $display("FAIL get_opcode got %0d exp 4", s_a_opcode); end
        tick();
        checks++; if (s_a_valid !== 1'b0) begin errors++; $display("FAIL get_drop got %b exp 0", s_a_valid); end
        m_d_ready = 2'b11;
        s_d_source = 5'h13;
        s_d_valid = 1'b1;
        #1;
        checks++; if (m_d_valid !== 2'b10) begin errors++; $display("FAIL d_valid got %b exp 10", m_d_valid); end
        checks++; if (m_d_source[7:4] !== 4'd3) begin errors++; $display("FAIL d_source got %h exp 3", m_d_source[7:4]); end
        checks++; if (m_d_data[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL d_data got %h exp deadbeef", m_d_data[63:32]); end
        checks++; if (s_d_ready !== 1'b1) begin errors++; $display("FAIL d_ready got %b exp 1", s_d_ready); end
        s_d_valid = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        set_a(0, 3'd4, 4'd2, 4'd1, 32'h10, 32'h0);
        set_a(1, 3'd4, 4'd2, 4'd2, 32'h20, 32'h0);
        m_a_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (m_a_ready !== (2'b01 << (i % 2))) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", i, m_a_ready, 2'b01 << (i % 2)); end
            tick();
            checks++; if (s_a_source !== ((i % 2) ? 5'h12 : 5'h01)) begin errors++; $display("FAIL rr_source[%0d] got %h exp %h", i, s_a_source, (i % 2) ? 5'h12 : 5'h01); end
        end
        m_a_valid = 2'b00;
        tick();
    endtask

    task automatic test_burst_lock();
        set_a(1, 3'd4, 4'd2, 4'd9, 32'h300, 32'h0);
        m_a_valid = 2'b11;
        for (int b = 0; b < 4; b++) begin
            set_a(0, 3'd0, 4'd4, 4'd5, 32'h200 + 32'(4*b), 32'hA0 + 32'(b));
            #1;
            checks++; if (m_a_ready !== 2'b01) begin errors++; $display("FAIL burst_ready[%0d] got %b exp 01", b, m_a_ready); end
            tick();
            checks++; if (s_a_source !== 5'h05) begin errors++; $display("FAIL burst_source[%0d] got %h exp 05", b, s_a_source); end
            checks++; if (s_a_data !== 32'hA0 + 32'(b)) begin errors++; $display("FAIL burst_data[%0d] got %h exp %h", b, s_a_data, 32'hA0 + 32'(b)); end
        end
        #1;
        checks++; if (m_a_ready !== 2'b10) begin errors++; $display("FAIL burst_release got %b exp 10", m_a_ready); end
        tick();
        m_a_valid = 2'b00;
        checks++; if (s_a_source !== 5'h19) begin errors++; $display("FAIL burst_next_source got %h exp 19", s_a_source); end
        tick();
    endtask

    task automatic test_backpressure();
        s_a_ready = 1'b0;
        set_a(0, 3'd4, 4'd2, 4'd5, 32'h400, 32'h0);
        m_a_valid = 2'b01;
        #1;
        checks++; if (m_a_ready !== 2'b01) begin errors++; $display("FAIL bp_first_ready got %b exp 01", m_a_ready); end
        tick();
        set_a(0, 3'd4, 4'd2, 4'd6, 32'h404, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (m_a_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 00", i, m_a_ready); end
            checks++; if (s_a_valid !== 1'b1 || s_a_address !== 32'h400 || s_a_source !== 5'h05) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b a=%h s=%h exp v=1 a=400 s=05", i, s_a_valid, s_a_address, s_a_source);
            end
            tick();
        end
        s_a_ready = 1'b1;
        #1;
        checks++; if (m_a_ready !== 2'b01) begin errors++; $display("FAIL bp_resume_ready got %b exp 01", m_a_ready); end
        tick();
        m_a_valid = 2'b00;
        checks++; if (s_a_address !== 32'h404 || s_a_source !== 5'h06) begin errors++; $display("FAIL bp_next got a=%h s=%h exp a=404 s=06", s_a_address, s_a_source); end
        tick();
        checks++; if (s_a_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %b exp 0", s_a_valid); end
    endtask

    task automatic test_d_backpressure();
        m_d_ready = 2'b10;
        s_d_source = 5'h07;
        s_d_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (m_d_valid !== 2'b01) begin errors++; $display("FAIL dbp_valid[%0d] got %b exp 01", i, m_d_valid); end
            checks++; if (s_d_ready !== 1'b0) begin errors++; $display("FAIL dbp_ready[%0d] got %b exp 0", i, s_d_ready); end
            tick();
        end
        m_d_ready = 2'b11;
        #1;
        checks++; if (s_d_ready !== 1'b1) begin errors++; $display("FAIL dbp_release got %b exp 1", s_d_ready); end
        checks++; if (m_d_source[3:0] !== 4'd7) begin errors++; $display("FAIL dbp_source got %h exp 7", m_d_source[3:0]); end
        tick();
        s_d_valid = 1'b0;
        #1;
        checks++; if (m_d_valid !== 2'b00) begin errors++; $display("FAIL dbp_idle got %b exp 00", m_d_valid); end
    endtask

    task automatic test_reset_mid_burst();
        s_a_ready = 1'b1;
        set_a(0, 3'd0, 4'd4, 4'd2, 32'h500, 32'h55);
        m_a_valid = 2'b01;
        tick();
        tick();
        checks++; if (s_a_valid !== 1'b1 || s_a_source !== 5'h02) begin errors++; $display("FAIL rmb_beat2 got v=%b s=%h exp v=1 s=02", s_a_valid, s_a_source); end
        rst = 1'b1;
        set_a(1, 3'd4, 4'd2, 4'd4, 32'h600, 32'h0);
        m_a_valid = 2'b10;
        tick();
        checks++; if (s_a_valid !== 1'b0) begin errors++; $display("FAIL rmb_valid got %b exp 0", s_a_valid); end
        rst = 1'b0;
        #1;
        checks++; if (m_a_ready !== 2'b10) begin errors++; $display("FAIL rmb_ready got %b exp 10", m_a_ready); end
        tick();
        m_a_valid = 2'b00;
        checks++; if (s_a_valid !== 1'b1 || s_a_source !== 5'h14) begin errors++; $display("FAIL rmb_get got v=%b s=%h exp v=1 s=14", s_a_valid, s_a_source); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_get();
        test_round_robin();
        test_burst_lock();
        test_backpressure();
        test_d_backpressure();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tilelink_n_to_1_arbiter.md
Name: tilelink_n_to_1_arbiter

Overview:
- Shares one TileLink-UL slave port between M masters: round-robin arbitration on channel A, with burst locking for multi-beat writes.
- Source IDs are widened with the master index; channel D responses are demultiplexed back to the originating master from those index bits.
- Sits upstream of the 1-to-N crossbar, or in front of a single shared slave (e.g. a memory controller), when several cores or DMA engines contend for it.

Parameters:
- M, 2: number of masters; must be ≥2.
- TL_DW, 32: data width in bits; power of 2, ≥32.
- TL_AW, 32: address width.
- TL_RS, 4: master-side source width.
- TL_SZ, 4: size field width.
- MW, $clog2(M): master-index width (localparam).

Ports:
- tilelink_clock_i  in  1  clock
- tilelink_reset_i  in  1  synchronous active-high reset
- master_a_opcode/param  in  3*M each  per-master A opcode/param
- master_a_size  in  TL_SZ*M  per-master log2 bytes
- master_a_source  in  TL_RS*M
- master_a_address  in  TL_AW*M
- master_a_mask  in  (TL_DW/8)*M
- master_a_data  in  TL_DW*M
- master_a_corrupt, master_a_valid  in  M
- master_a_ready  out  M
- master_d_opcode  out  3*M
- master_d_param  out  2*M
- master_d_size  out  TL_SZ*M
- master_d_source  out  TL_RS*M
- master_d_denied, master_d_corrupt, master_d_valid  out  M
- master_d_data  out  TL_DW*M
- master_d_ready  in  M
- slave_a_opcode/param  out  3 each
- slave_a_size  out  TL_SZ
- slave_a_source  out  TL_RS+MW; {master index, master source}
- slave_a_address  out  TL_AW
- slave_a_mask  out  TL_DW/8
- slave_a_data  out  TL_DW
- slave_a_corrupt, slave_a_valid  out  1
- slave_a_ready  in  1
- slave_d_opcode  in  3
- slave_d_param  in  2
- slave_d_size  in  TL_SZ
- slave_d_source  in  TL_RS+MW
- slave_d_denied, slave_d_corrupt, slave_d_valid  in  1
- slave_d_data  in  TL_DW
- slave_d_ready  out  1

Behaviour:
- **Reset:**
  - slave_a_* output register, all bits = 0, including slave_a_valid.
  - FSM = IDLE; rr pointer = 0; beat counter = 0; master_a_ready = 0.
- **Output register slot:**
  - Free when !slave_a_valid | slave_a_ready.
  - Accept-to-slave_a_valid latency is 1 cycle.
  - Throughput is 1 beat/cycle under continuous slave_a_ready.
  - slave_a_valid drops next cycle when the slot is free and no beat is accepted.
- **IDLE:**
  - If the slot is free, grant the first valid master at or after the rr pointer, wrapping modulo M.
  - master_a_ready is asserted only for the granted master, in the same cycle, combinationally from the valids.
  - Beat is captured into the output register; the source is prefixed with the grant index.
  - rr pointer becomes grant+1 (mod M) on every accepted first beat.
- **Burst detect:**
  - Burst when opcode ∈ {0 PutFullData, 1 PutPartialData} and size > log2(TL_DW/8).
  - beats = 1 << (size − log2(TL_DW/8)); size is limited to ≤12.
  - Counter (12 bits) loads beats−1; FSM → BURST with lock_idx = grant.
  - Get (opcode 4) is always single-beat on A regardless of size.
- **BURST:**
  - Only lock_idx may be ready; other masters' ready = 0.
  - Each accepted beat decrements the counter.
  - The beat accepted with counter==1 returns the FSM to IDLE in the next cycle.
  - Bubbles (lock_idx master not valid) keep the lock; no timeout.
- **Channel D:**
  - Combinational demux: idx = slave_d_source[TL_RS+MW-1:TL_RS].
  - master_d_valid[idx] = slave_d_valid; all other master_d_valid = 0.
  - D payload fields are driven to every master; only valid is qualified.
  - slave_d_ready = master_d_ready[idx].
  - master_d_source = low TL_RS bits of slave_d_source.
  - An idx ≥ M (non-power-of-2 M) is dropped: slave_d_ready = 1 and no master sees valid.
- **A/D independence:** A and D paths are independent; simultaneous A grant and D response are both legal.
- **Reset mid-burst:** FSM to IDLE, counter cleared, slave_a_valid = 0. Partial bursts are abandoned; upstream must be reset together.

Test Plan:
- **Single Get:** M=2, TL_DW=32. Master1 Get addr 0x100, size 2, source 3. Required:
  - next cycle slave_a_valid=1, slave_a_source=0x13 (idx1, src3);
  - slave D source 0x13 → master_d_valid=2'b10, master_d_source=3.
- **Round-robin fairness:** both masters hold Gets for 4 cycles with slave_a_ready=1 → grant order 0,1,0,1 starting from reset pointer 0.
- **Burst lock:** master0 PutFullData size 4 (4 beats) while master1 valid. Required:
  - 4 consecutive slave beats all from master0 (source idx 0), master_a_ready[1]=0 throughout;
  - master1 granted on the following cycle.
- **Backpressure:** slave_a_ready=0 for 3 cycles with one beat held → slave_a_* stable, master_a_ready all 0, no beat lost or duplicated; resumes when ready=1.
- **D backpressure:** response to master0 while master_d_ready[0]=0 → slave_d_ready=0 until master_d_ready[0]=1, and master1 sees no valid.
- **Reset mid-burst:** reset after beat 2 of a 4-beat PutFullData → next cycle slave_a_valid=0 and FSM IDLE; a new master1 Get is granted normally.
